// File: rtl/image_pixel_packer_writer.sv
// image_pixel_packer_writer
//   Packs an 8-bit grayscale Avalon-ST pixel stream into little-endian 32-bit
//   words (4 pixels per word) and writes them through an Avalon-MM master
//   into a single-port on-chip image RAM, starting at a programmed base word
//   address. A small CSR slave starts, aborts and polls a transfer; irq is a
//   level interrupt raised when a frame is stored and enabled.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   csr_*                : CSR slave (0 control/status, 1 base, 2 count,
//                          3 checksum); csr_readdata is registered (latency 1)
//   snk_*                : pixel stream sink (data, valid, ready, endofpacket)
//   mem_*                : RAM write master (address, byteenable, chipselect,
//                          write, writedata); all outputs registered
//   irq                  : done & irq_en
//
// Optional build macro
//   PIXPACK_CHECKSUM_EN  : reg 3 returns the 32-bit wrap-around sum of the
//                          pixels accepted in the current frame; otherwise 0.
module image_pixel_packer_writer #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 10000,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        csr_address,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   input  logic              csr_read,
   output logic [31:0]       csr_readdata,
   input  logic [7:0]        snk_data,
   input  logic              snk_valid,
   output logic              snk_ready,
   input  logic              snk_endofpacket,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              irq
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base, ptr;
   logic [CNT_W-1:0]  count, pix;
   logic [1:0]        lane;
   logic [31:0]       pack, packed_word;
   logic [15:0]       words_written;
   logic              irq_en, done, range_err, short_f, aborted;
   logic [31:0]       cksum;

   logic ctrl_wr, start_req, abort_req, clear_req, active, abort_now;
   logic accept, cnt_hit, last_pix, issue, range_bad, valid_start;
   logic [31:0] span_end, status, rd_mux;
   logic [3:0]  lane_be;

   assign ctrl_wr   = csr_write && (csr_address == 2'd0);
   assign start_req = ctrl_wr && csr_writedata[0];
   assign abort_req = ctrl_wr && csr_writedata[2];
   assign clear_req = ctrl_wr && csr_writedata[3];

   assign active    = (state == S_RUN) || (state == S_FLUSH);
   assign abort_now = abort_req && active;
   assign snk_ready = (state == S_RUN);
   assign accept    = snk_valid && snk_ready;
   assign cnt_hit   = ({1'b0, pix} + (CNT_W+1)'(1)) == {1'b0, count};
   assign last_pix  = cnt_hit || snk_endofpacket;
   // A pixel taken in the abort cycle is dropped along with the partial word.
   assign issue     = accept && ((lane == 2'd3) || last_pix) && !abort_now;

   // One past the last word the frame would touch; must not exceed DEPTH.
   assign span_end    = 32'(base) + ((32'(count) + 32'd3) >> 2);
   assign range_bad   = (count == '0) || (span_end > 32'(DEPTH));
   assign valid_start = (state == S_IDLE) && start_req && !abort_req && !range_bad;

   // Packing register plus the pixel arriving this cycle; the output word
   // register is loaded from this so acceptance never stalls on a write.
   always_comb begin
      packed_word = pack;
      lane_be     = 4'hF;
      case (lane)
         2'd0:    begin packed_word[7:0]   = snk_data; lane_be = 4'h1; end
         2'd1:    begin packed_word[15:8]  = snk_data; lane_be = 4'h3; end
         2'd2:    begin packed_word[23:16] = snk_data; lane_be = 4'h7; end
         default: begin packed_word[31:24] = snk_data; lane_be = 4'hF; end
      endcase
   end

   assign status = {words_written, 10'd0, irq_en, aborted, short_f, range_err, done, active};

   always_comb begin
      case (csr_address)
         2'd0:    rd_mux = status;
         2'd1:    rd_mux = 32'(base);
         2'd2:    rd_mux = 32'(count);
         default: rd_mux = cksum;
      endcase
   end

   assign irq = done && irq_en;

`ifdef PIXPACK_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    cksum <= '0;
      else if (valid_start)         cksum <= '0;
      else if (accept && !abort_now) cksum <= cksum + 32'(snk_data);
   end
`else
   assign cksum = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         base           <= '0;
         count          <= '0;
         ptr            <= '0;
         pix            <= '0;
         lane           <= '0;
         pack           <= '0;
         words_written  <= '0;
         irq_en         <= 1'b0;
         done           <= 1'b0;
         range_err      <= 1'b0;
         short_f        <= 1'b0;
         aborted        <= 1'b0;
         csr_readdata   <= '0;
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
      end else begin
         mem_write      <= 1'b0;
         mem_chipselect <= 1'b0;

         if (csr_write && csr_address == 2'd1) base  <= csr_writedata[ADDR_W-1:0];
         if (csr_write && csr_address == 2'd2) count <= csr_writedata[CNT_W-1:0];
         if (ctrl_wr) irq_en <= csr_writedata[1];
         if (csr_read) csr_readdata <= rd_mux;

         case (state)
            S_IDLE: begin
               if (start_req && !abort_req) begin
                  if (range_bad) begin
                     range_err <= 1'b1;
                  end else begin
                     done          <= 1'b0;
                     range_err     <= 1'b0;
                     short_f       <= 1'b0;
                     aborted       <= 1'b0;
                     words_written <= '0;
                     ptr           <= base;
                     lane          <= '0;
                     pix           <= '0;
                     pack          <= '0;
                     state         <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (abort_now) begin
                  aborted <= 1'b1;
                  pack    <= '0;
                  lane    <= '0;
                  state   <= S_IDLE;
               end else if (accept) begin
                  pix <= pix + CNT_W'(1);
                  if (issue) begin
                     mem_write      <= 1'b1;
                     mem_chipselect <= 1'b1;
                     mem_address    <= ptr;
                     mem_writedata  <= packed_word;
                     mem_byteenable <= lane_be;
                     ptr            <= ptr + ADDR_W'(1);
                     words_written  <= words_written + 16'd1;
                     pack           <= '0;
                     lane           <= '0;
                  end else begin
                     pack <= packed_word;
                     lane <= lane + 2'd1;
                  end
                  if (last_pix) begin
                     short_f <= snk_endofpacket && !cnt_hit;
                     state   <= S_FLUSH;
                  end
               end
            end
            // The final write sits on mem_* during this cycle.
            S_FLUSH: begin
               if (abort_now) begin
                  aborted <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               if (clear_req) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_pixel_packer_writer.sv
module tb_image_pixel_packer_writer;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 10000;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0, rst = 1'b1;
   logic [1:0]        csr_address = '0;
   logic              csr_write = 1'b0, csr_read = 1'b0;
   logic [31:0]       csr_writedata = '0, csr_readdata;
   logic [7:0]        snk_data = '0;
   logic              snk_valid = 1'b0, snk_ready, snk_endofpacket = 1'b0;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect, mem_write, irq;
   logic [31:0]       mem_writedata;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
      logic [3:0]        be;
      logic              cs;
   } wr_t;

   wr_t got[$];
   int  checks = 0, errors = 0, cycle = 0;

   image_pixel_packer_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(rst),
      .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
      .csr_read(csr_read), .csr_readdata(csr_readdata),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
      .snk_endofpacket(snk_endofpacket),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Every write strobe seen on the RAM port, sampled mid-cycle.
   always @(negedge clk)
      if (mem_write === 1'b1)
         got.push_back('{mem_address, mem_writedata, mem_byteenable, mem_chipselect});

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      @(negedge clk);
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      csr_address = a; csr_read = 1'b1;
      @(negedge clk);
      csr_read = 1'b0;
      d = csr_readdata;
   endtask

   // Present one pixel; returns at the negedge after it was taken.
   task automatic send_px(input logic [7:0] d, input bit eop);
      int tmo = 0;
      snk_valid = 1'b1; snk_data = d; snk_endofpacket = eop;
      while (snk_ready !== 1'b1 && tmo < 50) begin @(negedge clk); tmo++; end
      if (tmo >= 50) begin
         checks++; errors++;
         $display("FAIL send_px_timeout ready never rose for pixel %02h", d);
      end
      @(negedge clk);
   endtask

   // Program, stream and verify one frame against a word-level model.
   task automatic run_frame(input int base, input int cnt, input int eop_at,
                            input int first, input bit gaps, input bit irqen);
      logic [7:0]  px[$];
      logic [31:0] st, exp_st, sum, ed, m;
      logic [3:0]  ebe;
      int n, nw, c0, k;
      bit rdy_seen;
      px.delete();
      for (int i = 0; i < cnt; i++)
         px.push_back(first < 0 ? 8'($urandom) : 8'(first + i));
      n  = (eop_at >= 0 && eop_at < cnt) ? eop_at + 1 : cnt;
      nw = (n + 3) / 4;
      csr_wr(2'd1, 32'(base));
      csr_wr(2'd2, 32'(cnt));
      got.delete();
      csr_wr(2'd0, irqen ? 32'h3 : 32'h1);
      c0 = cycle;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            snk_valid = 1'b0; @(negedge clk);
         end
         send_px(px[i], i == eop_at);
      end
      if (!gaps) begin
         checks++;
         if (cycle - c0 !== n) begin
            errors++;
            $display("FAIL back_to_back took %0d cycles want %0d", cycle - c0, n);
         end
      end
      snk_endofpacket = 1'b0;
      checks++;
      if (snk_ready !== 1'b0) begin
         errors++; $display("FAIL ready_drop ready=%b want 0", snk_ready);
      end
      // An extra pixel must not be taken.
      snk_data = 8'($urandom); rdy_seen = 0;
      repeat (3) begin @(negedge clk); if (snk_ready !== 1'b0) rdy_seen = 1; end
      snk_valid = 1'b0;
      checks++;
      if (rdy_seen) begin errors++; $display("FAIL extra_pixel ready rose after frame"); end
      repeat (2) @(negedge clk);

      checks++;
      if (got.size() != nw) begin
         errors++; $display("FAIL write_count got %0d want %0d", got.size(), nw);
      end
      for (int w = 0; w < nw && w < got.size(); w++) begin
         k   = (n - 4 * w) >= 4 ? 4 : n - 4 * w;
         ebe = 4'((1 << k) - 1);
         ed  = '0;
         for (int b = 0; b < k; b++) ed[8*b +: 8] = px[4*w + b];
         m = {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}};
         checks++;
         if (got[w].a !== ADDR_W'(base + w) || got[w].be !== ebe ||
             (got[w].d & m) !== ed || got[w].cs !== 1'b1) begin
            errors++;
            $display("FAIL write%0d got a=%0d d=%08h be=%h cs=%b want a=%0d d=%08h be=%h cs=1",
                     w, got[w].a, got[w].d, got[w].be, got[w].cs, base + w, ed, ebe);
         end
      end

      exp_st = {16'(nw), 10'd0, irqen, 1'b0, (n < cnt), 1'b0, 1'b1, 1'b0};
      csr_rd(2'd0, st);
      checks++;
      if (st !== exp_st) begin errors++; $display("FAIL status got %08h want %08h", st, exp_st); end
      checks++;
      if (irq !== irqen) begin errors++; $display("FAIL irq got %b want %b", irq, irqen); end

      sum = '0;
      for (int i = 0; i < n; i++) sum += 32'(px[i]);
`ifndef PIXPACK_CHECKSUM_EN
      sum = '0;
`endif
      csr_rd(2'd3, st);
      checks++;
      if (st !== sum) begin errors++; $display("FAIL checksum got %08h want %08h", st, sum); end

      csr_wr(2'd0, irqen ? 32'hA : 32'h8);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
      csr_rd(2'd0, st);
      checks++;
      if (st[1:0] !== 2'b00) begin errors++; $display("FAIL clear_done status[1:0]=%b want 00", st[1:0]); end
   endtask

   task automatic test_reset();
      logic [31:0] st;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata} !== '0) begin
         errors++; $display("FAIL reset_mem got we=%b cs=%b be=%h a=%0d d=%08h want all 0",
                             mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata);
      end
      checks++;
      if ({snk_ready, irq, csr_readdata} !== '0) begin
         errors++; $display("FAIL reset_misc ready=%b irq=%b rd=%08h want 0", snk_ready, irq, csr_readdata);
      end
      rst = 1'b0;
      @(negedge clk);
      csr_rd(2'd0, st);
      checks++;
      if (st !== 32'h0) begin errors++; $display("FAIL reset_status got %08h want 0", st); end
   endtask

   task automatic test_full_words();
      run_frame(100, 8, -1, 8'h11, 0, 1);
      checks++;
      if (got.size() != 2 || got[0].d !== 32'h14131211 || got[1].d !== 32'h18171615) begin
         errors++; $display("FAIL full_words data mismatch in fixed 8-pixel frame");
      end
   endtask

   task automatic test_partial();
      run_frame(300, 6, -1, 8'hA0, 0, 0);
      checks++;
      if (got.size() != 2 || got[1].a !== ADDR_W'(301) || got[1].d[15:0] !== 16'hA5A4 ||
          got[1].be !== 4'h3) begin
         errors++; $display("FAIL partial second write wrong (want a=301 d=..A5A4 be=3)");
      end
   endtask

   task automatic test_range();
      logic [31:0] st;
      got.delete();
      csr_wr(2'd1, 32'd9999);
      csr_wr(2'd2, 32'd5);
      csr_wr(2'd0, 32'h1);
      repeat (4) @(negedge clk);
      csr_rd(2'd0, st);
      checks++;
      if (st[2:0] !== 3'b100) begin errors++; $display("FAIL range_err status[2:0]=%b want 100", st[2:0]); end
      checks++;
      if (got.size() != 0 || snk_ready !== 1'b0) begin
         errors++; $display("FAIL range_no_write writes=%0d ready=%b want 0", got.size(), snk_ready);
      end
      run_frame(9998, 8, -1, -1, 1, 0);
      checks++;
      if (got.size() != 2 || got[1].a !== ADDR_W'(9999)) begin
         errors++; $display("FAIL range_edge last write address wrong (want 9999)");
      end
   endtask

   task automatic test_short();
      run_frame(500, 12, 4, -1, 0, 1);
      checks++;
      if (got.size() != 2 || got[1].be !== 4'h1) begin
         errors++; $display("FAIL short_frame writes=%0d want 2 with final be 1", got.size());
      end
   endtask

   task automatic test_abort();
      logic [31:0] st;
      csr_wr(2'd1, 32'd50);
      csr_wr(2'd2, 32'd12);
      got.delete();
      csr_wr(2'd0, 32'h1);
      for (int i = 0; i < 3; i++) send_px(8'($urandom), 1'b0);
      snk_valid = 1'b0;
      csr_wr(2'd0, 32'h5);   // start+abort: abort wins
      repeat (3) @(negedge clk);
      csr_rd(2'd0, st);
      checks++;
      if (st !== 32'h10) begin errors++; $display("FAIL abort_status got %08h want 00000010", st); end
      checks++;
      if (got.size() != 0) begin errors++; $display("FAIL abort_writes got %0d want 0", got.size()); end
      run_frame(60, 7, -1, -1, 1, 1);
   endtask

   task automatic test_random();
      int cnt, base, eop;
      for (int t = 0; t < 6; t++) begin
         cnt  = $urandom_range(1, 40);
         base = $urandom_range(0, DEPTH - (cnt + 3) / 4);
         eop  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt - 1) : -1;
         run_frame(base, cnt, eop, -1, 1, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] st;
      csr_wr(2'd1, 32'd200);
      csr_wr(2'd2, 32'd20);
      csr_wr(2'd0, 32'h3);
      for (int i = 0; i < 4; i++) send_px(8'($urandom), 1'b0);
      snk_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata,
           snk_ready, irq, csr_readdata} !== '0) begin
         errors++; $display("FAIL reset_mid_run outputs we=%b cs=%b ready=%b irq=%b want all 0",
                             mem_write, mem_chipselect, snk_ready, irq);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      csr_rd(2'd0, st);
      checks++;
      if (st !== 32'h0) begin errors++; $display("FAIL reset_mid_status got %08h want 0", st); end
      run_frame(10, 9, -1, -1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_partial();
      test_range();
      test_short();
      test_abort();
      test_random();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/image_pixel_packer_writer.md
Name: image_pixel_packer_writer

Overview:
- Avalon-MM write master sitting directly upstream of a processor's 32-bit on-chip image RAM (single-port, 14-bit word address, 10000 words, byte enables, no waitrequest, 1-cycle writes).
- Accepts an 8-bit grayscale pixel stream (Avalon-ST), packs 4 pixels per little-endian word and writes them to the RAM from a programmed base word address.
- A small CSR slave lets the Nios start, abort and poll a transfer; the block raises an interrupt when the frame is stored.

Parameters:
- ADDR_W, 14, RAM word address width.
- DEPTH, 10000, RAM depth in words; the last legal word address is DEPTH-1.
- CNT_W, 16, pixel count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- csr_address  in  2  CSR word select.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_read  in  1  CSR read strobe.
- csr_readdata  out  32  CSR read data, registered.
- snk_data  in  8  pixel.
- snk_valid  in  1  pixel valid.
- snk_ready  out  1  pixel accepted when valid&ready.
- snk_endofpacket  in  1  last pixel of frame.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  lane enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  packed pixels.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async) sets all of the following to 0 and FSM=IDLE:
  - outputs: csr_readdata, snk_ready, mem_*, irq;
  - registers: base, count, pointers, lane, flags.
- CSR map:
  - 0: write = control {bit0 start, bit1 irq_en, bit2 abort, bit3 clear_done}; read = status {bit0 busy, bit1 done, bit2 range_err, bit3 short, bit4 aborted, bit5 irq_en, [31:16] words_written}.
  - 1: base word address [ADDR_W-1:0].
  - 2: pixel count [CNT_W-1:0].
  - 3: read-only, see Optional Feature.
- csr_readdata updates the cycle after csr_read (latency 1).
- States: IDLE, RUN, FLUSH, DONE.
- IDLE, on start:
  - If count==0 or base+ceil(count/4)-1 > DEPTH-1: set range_err, stay IDLE.
  - Otherwise clear done, range_err, short, aborted and words_written; ptr=base, lane=0, pix=0; go RUN.
  - start in any other state is ignored.
- RUN:
  - snk_ready=1. An accepted pixel goes to lane bits [8*lane+7:8*lane]; lane++ and pix++.
  - When lane 3 is filled, the word plus byteenable 4'hF is registered to the mem_* outputs. mem_write and mem_chipselect are high exactly one cycle, the cycle after the 4th pixel is accepted. ptr++ after each write.
  - Acceptance continues back-to-back with no bubble; the output register is separate from the packing register.
- Last pixel (pix+1==count, or snk_endofpacket):
  - Partial word written with byteenable covering filled lanes only (1 lane->4'h1, 2->4'h3, 3->4'h7).
  - snk_ready drops the cycle after acceptance; go FLUSH.
  - EOP before count reached sets short.
- FLUSH: wait for the final write cycle to complete, then go DONE.
- DONE:
  - done=1, snk_ready=0, busy=0.
  - irq = done & irq_en.
  - clear_done -> IDLE, irq low next cycle.
- Pixels past count are never accepted: ready is low, so there is no spill into the next frame.
- abort in RUN/FLUSH:
  - Next cycle go IDLE, set aborted; the pending partial word is discarded and done is not set.
  - A write already on the mem_* outputs in that cycle completes.
- If start and abort are written together, abort wins.
- words_written counts issued writes, partial ones included.
- Address never exceeds DEPTH-1; this is guaranteed by the start check.

Optional Feature:
- PIXPACK_CHECKSUM_EN defined: reg 3 returns a 32-bit wrap-around sum of all accepted pixels (zero-extended) in the current frame, cleared on a valid start.
- Undefined: reg 3 reads 0 and no adder is built.

Test Plan:
- base=100, count=8, pixels 0x11..0x18 streamed every cycle.
  - Required: writes to addr 100 data 0x14131211 be F, then addr 101 data 0x18171615 be F.
  - Then done=1, words_written=2, irq=1 when irq_en.
- count=6, pixels 0xA0..0xA5.
  - Required: second write addr base+1 data 0x0000A5A4 (upper lanes don't-care) be 4'h3.
  - After the 6th pixel, snk_ready=0 and a 7th valid pixel is not consumed.
- count=12, snk_endofpacket on the 5th pixel.
  - Required: 2 writes (2nd be 4'h1), short=1, done=1.
- base=9999, count=5.
  - Required: range_err=1, busy=0, no mem_write.
  - Then base=9998, count=8 is accepted; the last write lands at addr 9999.
- Abort after 3 pixels.
  - Required: no write issued, aborted=1, done=0, IDLE; a new start then works normally.
- Assert reset mid-RUN for 1 cycle.
  - Required: all outputs 0 immediately, state IDLE, status reads 0.
- With PIXPACK_CHECKSUM_EN: the 8-pixel frame of the first test reads 0x000000A4 at reg 3.
